// File: rtl/preg_free_list_pkg.sv
// Shared rename-stage constants and types.
// The rename table and the ROB reuse preg_t and fl_ptr_t.
package preg_free_list_pkg;

  localparam int P_REGISTERS = 64;
  localparam int L_REGS      = 32;
  localparam int INSTR_COUNT = 2;
  localparam int C_NUM       = 16;

  localparam int FL_DEPTH = P_REGISTERS - L_REGS;
  localparam int PA_W     = $clog2(P_REGISTERS);
  localparam int PTR_W    = $clog2(FL_DEPTH) + 1;
  localparam int IDX_W    = PTR_W - 1;
  localparam int CID_W    = $clog2(C_NUM);
  localparam int CNT_W    = $clog2(FL_DEPTH + 1);
  localparam int NUM_W    = $clog2(INSTR_COUNT + 1);

  typedef logic [PTR_W-1:0] fl_ptr_t;
  typedef logic [PA_W-1:0]  preg_t;
  typedef logic [IDX_W-1:0] fl_idx_t;
  typedef logic [CID_W-1:0] cid_t;
  typedef logic [CNT_W-1:0] fl_cnt_t;

  function automatic fl_idx_t fl_idx(
    input fl_ptr_t p
  );
    return fl_idx_t'(p);
  endfunction

endpackage

// File: rtl/preg_free_list_if.sv
// Rename-side allocate and commit-side release bundle.
// master = pipeline, slave = free list.
interface preg_free_list_if;
  import preg_free_list_pkg::*;

  logic [NUM_W-1:0]              alloc_num;
  logic                          alloc_ready;
  logic [INSTR_COUNT*PA_W-1:0]   alloc_preg;
  logic [INSTR_COUNT-1:0]        rel_valid;
  logic [INSTR_COUNT*PA_W-1:0]   rel_preg;

  modport master (
    output alloc_num,
    output rel_valid,
    output rel_preg,
    input  alloc_ready,
    input  alloc_preg
  );

  modport slave (
    input  alloc_num,
    input  rel_valid,
    input  rel_preg,
    output alloc_ready,
    output alloc_preg
  );

endinterface

// File: rtl/preg_free_list_ckpt_table.sv
// Per-branch snapshot of the free-list head.
// One write port, one combinational read port.
module fl_ckpt_table
  import preg_free_list_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    we_i,
  input  cid_t    waddr_i,
  input  fl_ptr_t wdata_i,
  input  cid_t    raddr_i,
  output fl_ptr_t rdata_o
);

  fl_ptr_t tbl_q [C_NUM];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < C_NUM; i++) begin
        tbl_q[i] <= '0;
      end
    end else if (we_i) begin
      tbl_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = tbl_q[raddr_i];

endmodule

// File: rtl/preg_free_list.sv
// Circular free list of physical registers with
// per-branch head checkpoints for one-cycle restore.
module preg_free_list
  import preg_free_list_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  preg_free_list_if.slave fl,
  input  logic    ckpt_valid,
  input  cid_t    ckpt_id,
  input  logic    restore_valid,
  input  cid_t    restore_id,
  output fl_cnt_t free_count,
  output logic    overflow_err
);

  fl_ptr_t head_q;
  fl_ptr_t head_d;
  fl_ptr_t tail_q;
  fl_ptr_t tail_d;
  fl_ptr_t head_alloc;
  fl_ptr_t ckpt_rdata;
  logic    ovf_q;
  logic    ovf_d;
  logic    grant;
  logic    drop;
  fl_cnt_t room;
  fl_cnt_t wr_cnt;
  preg_t   mem_q [FL_DEPTH];

  logic [INSTR_COUNT-1:0]      wr_en;
  fl_ptr_t                     wr_ptr [INSTR_COUNT];
  logic [INSTR_COUNT*PA_W-1:0] alloc_bus;

  assign free_count = fl_cnt_t'(tail_q - head_q);

  assign fl.alloc_ready = !restore_valid &&
    (fl_cnt_t'(fl.alloc_num) <= free_count);

  assign grant = fl.alloc_ready &&
    (fl.alloc_num != '0);

  assign head_alloc = grant ?
    head_q + fl_ptr_t'(fl.alloc_num) : head_q;

  assign head_d = restore_valid ?
    ckpt_rdata : head_alloc;

  always_comb begin
    alloc_bus = '0;
    for (int k = 0; k < INSTR_COUNT; k++) begin
      alloc_bus[k*PA_W +: PA_W] =
        mem_q[fl_idx(head_q + fl_ptr_t'(k))];
    end
  end

  assign fl.alloc_preg = alloc_bus;

  // Room is measured after this cycle's grant; releases
  // beyond it are dropped and flagged.
  always_comb begin
    room   = fl_cnt_t'(FL_DEPTH) -
             fl_cnt_t'(tail_q - head_alloc);
    wr_cnt = '0;
    drop   = 1'b0;
    for (int k = 0; k < INSTR_COUNT; k++) begin
      wr_en[k]  = 1'b0;
      wr_ptr[k] = tail_q + fl_ptr_t'(wr_cnt);
      if (fl.rel_valid[k]) begin
        if (wr_cnt < room) begin
          wr_en[k] = 1'b1;
          wr_cnt   = wr_cnt + fl_cnt_t'(1);
        end else begin
          drop = 1'b1;
        end
      end
    end
    tail_d = tail_q + fl_ptr_t'(wr_cnt);
    ovf_d  = ovf_q | drop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= fl_ptr_t'(FL_DEPTH);
      ovf_q  <= 1'b0;
      for (int i = 0; i < FL_DEPTH; i++) begin
        mem_q[i] <= preg_t'(L_REGS + i);
      end
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      ovf_q  <= ovf_d;
      for (int k = 0; k < INSTR_COUNT; k++) begin
        if (wr_en[k]) begin
          mem_q[fl_idx(wr_ptr[k])] <=
            fl.rel_preg[k*PA_W +: PA_W];
        end
      end
    end
  end

  assign overflow_err = ovf_q;

  fl_ckpt_table u_ckpt (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (ckpt_valid && !restore_valid),
    .waddr_i (ckpt_id),
    .wdata_i (head_alloc),
    .raddr_i (restore_id),
    .rdata_o (ckpt_rdata)
  );

endmodule
